chrono_lap_core: RTL and testbench
==================================

Name: chrono_lap_core

Overview:
Parametrised stopwatch/timer core for the LCD chronometer designs. It replaces the separate state machine, synchronous counters, latch and divider glue with a single block. The block does BCD mm:ss:cc time keeping, counts up or down with preset load, and stores laps in a circular multi-entry memory. It sits between the debounced push-button monostables and the LCD formatter. It runs entirely on the board quartz clock; there are no derived clocks.

Parameters:
TICK_DIV, 500000, clk_in cycles per centisecond tick (50 MHz -> 100 Hz); legal range >= 2.
LAP_DEPTH, 4, number of lap memory entries; power of two, 2..16.
LAP_AW, 2, log2(LAP_DEPTH); width of lap pointers and indices.

Ports:
clk_in  in  1  quartz clock; all logic on posedge.
reset_n  in  1  asynchronous, active-low reset.
btn_ss  in  1  start/stop level, already debounced and synchronous to clk_in.
btn_lr  in  1  lap/reset level, already debounced and synchronous to clk_in.
mode_down  in  1  0 = count up, 1 = count down; sampled only in IDLE.
load  in  1  loads preset_bcd into the time register; honoured only in IDLE.
preset_bcd  in  24  preset value as {m1,m0,s1,s0,c1,c0}, one BCD digit per 4-bit nibble.
lap_sel  in  LAP_AW  lap readout index; 0 = most recent lap.
time_bcd  out  24  live time, same digit layout as preset_bcd.
disp_bcd  out  24  display value: time_bcd, or the frozen lap while in a LAP state.
lap_rd_bcd  out  24  lap entry selected by lap_sel, registered.
lap_count  out  LAP_AW+1  number of valid laps; saturates at LAP_DEPTH.
state  out  3  FSM state code.
running  out  1  high in RUN and LAP_RUN.
lap_hold  out  1  high in LAP_RUN and LAP_STOP.
overflow  out  1  sticky flag; set on up-count wrap.
done  out  1  one-cycle pulse when a countdown reaches zero.

Behaviour:
- Asynchronous reset (reset_n low): every output is 0, state = IDLE, prescaler = 0, lap pointers = 0, lap memory contents don't-care.
- Edge detect: each button is registered into an _old register. An event is btn & !btn_old & !(other button). If both buttons rise in the same cycle, both events are ignored.
- State encoding: IDLE=000, STOP=001, RUN=010, LAP_RUN=011, LAP_STOP=100.
- State transitions, taking effect on the clock edge where the event is sampled:
  - IDLE: SS -> RUN. LR -> no action.
  - RUN: SS -> STOP. LR -> LAP_RUN, and the lap is captured.
  - LAP_RUN: SS -> LAP_STOP. LR -> RUN.
  - LAP_STOP: SS -> LAP_RUN. LR -> STOP.
  - STOP: SS -> RUN. LR -> IDLE, clearing the time register, overflow, lap_count, write pointer and prescaler.
- Prescaler: advances only when running. tick = (prescaler == TICK_DIV-1); on tick the prescaler returns to 0. Leaving the running states holds the prescaler value. Only IDLE or reset clears it.
- Time arithmetic: centiseconds 00..99, seconds 00..59, minutes 00..59, each BCD digit kept in range.
- Up count: each tick adds 1 with carry chain c0 -> c1 -> s0 -> s1 -> m0 -> m1. 59:59:99 + 1 wraps to 00:00:00 and sets overflow. Counting continues after the wrap.
- Down count: each tick subtracts 1 with borrow. The tick that reaches 00:00:00 also forces the state to STOP and pulses done for one cycle. SS in IDLE or STOP with time = 0 in down mode is ignored (no start).
- load in IDLE: time <= preset_bcd only if every digit is within its field range; otherwise load is ignored. load in any other state is ignored.
- Lap capture: lap_mem[wr_ptr] <= time_bcd as it stands in that cycle (the pre-increment value if a tick coincides). The frozen display register takes the same value. wr_ptr advances modulo LAP_DEPTH; lap_count increments, saturating at LAP_DEPTH. Once full, the oldest entry is overwritten.
- disp_bcd: shows the frozen lap value in LAP states, otherwise time_bcd.
- lap_rd_bcd: = lap_mem[(wr_ptr-1-lap_sel) mod LAP_DEPTH], one cycle latency. Reads 0 when lap_sel >= lap_count.
- Simultaneous tick and state event: the tick is applied and the state transition also happens on the same edge.
- A stop takes effect after any coincident increment.
- Latency: button rise to new state = 1 cycle. Tick edge to new time_bcd = 1 cycle.

Test Plan:
All scenarios use TICK_DIV=4 and LAP_DEPTH=4.
- Reset mid-run (reset_n low for 3 cycles, async to clk_in) -> all outputs 0 immediately; state=000.
- SS pulse, then 400 clocks -> time_bcd=00:01:00 (0x000100); running=1. SS pulse -> state=001, time held.
- From RUN, 5 LR/LR pairs, each pair separated by 8 clocks -> lap_count=4; lap_sel=0 returns the newest value; lap_sel=3 returns the 2nd capture (1st overwritten). disp_bcd frozen during LAP_RUN.
- preset 59:59:98 loaded, up mode, run 8 clocks -> time 00:00:00, overflow=1. load of 0x0A0000 in IDLE -> ignored.
- mode_down=1, preset 00:00:02, run -> after 8 clocks: time=0, done pulses once, state=001. SS then ignored.
- btn_ss and btn_lr rising together in RUN -> no state change. LR in LAP_STOP -> STOP; then LR -> IDLE with lap_count=0.

Source files
------------

// File: rtl/chrono_lap_core_if.sv
`default_nettype none
// ============================================================================
// Module      : chrono_lap_core_if
// Description : Button/preset/lap-select inputs and time/lap/status outputs
//               of the stopwatch core, bundled as one interface.
// Revision    : 1.0 - initial release
// ============================================================================
interface chrono_lap_core_if #(
  parameter int LAP_AW = 2
);
  logic              btn_ss;
  logic              btn_lr;
  logic              mode_down;
  logic              load;
  logic [23:0]       preset_bcd;
  logic [LAP_AW-1:0] lap_sel;
  logic [23:0]       time_bcd;
  logic [23:0]       disp_bcd;
  logic [23:0]       lap_rd_bcd;
  logic [LAP_AW:0]   lap_count;
  logic [2:0]        state;
  logic              running;
  logic              lap_hold;
  logic              overflow;
  logic              done;

  // Button/formatter side: drives controls, observes time and status
  modport master (
    output btn_ss, btn_lr, mode_down, load, preset_bcd, lap_sel,
    input  time_bcd, disp_bcd, lap_rd_bcd, lap_count, state,
           running, lap_hold, overflow, done
  );

  // Core side
  modport slave (
    input  btn_ss, btn_lr, mode_down, load, preset_bcd, lap_sel,
    output time_bcd, disp_bcd, lap_rd_bcd, lap_count, state,
           running, lap_hold, overflow, done
  );
endinterface
`default_nettype wire

// File: rtl/chrono_lap_core.sv
`default_nettype none
// ============================================================================
// Module      : chrono_lap_core
// Description : BCD mm:ss:cc stopwatch/timer with up/down count, preset
//               load and a circular lap memory. Single clock domain.
// Revision    : 1.0 - initial release
// ============================================================================
module chrono_lap_core #(
  parameter int TICK_DIV  = 500000,
  parameter int LAP_DEPTH = 4,
  parameter int LAP_AW    = 2
) (
  input  logic                    clk_in,
  input  logic                    reset_n,
  chrono_lap_core_if.slave        bus
);

  localparam int                c_PW       = $clog2(TICK_DIV);
  localparam logic [c_PW-1:0]   c_TICK_MAX = c_PW'(TICK_DIV - 1);
  localparam logic [LAP_AW:0]   c_LAP_FULL = (LAP_AW + 1)'(LAP_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE     = 3'b000,
    S_STOP     = 3'b001,
    S_RUN      = 3'b010,
    S_LAP_RUN  = 3'b011,
    S_LAP_STOP = 3'b100
  } state_t;

  // Digit index 0..5 = c0,c1,s0,s1,m0,m1; tens of seconds/minutes stop at 5
  function automatic logic [3:0] f_lim(input int i);
    return (i == 3 || i == 5) ? 4'd5 : 4'd9;
  endfunction

  // Increment with digit-wise carry; bit 24 flags the 59:59:99 wrap
  function automatic logic [24:0] f_inc(input logic [23:0] t);
    logic [23:0] v;
    logic        c;
    v = t;
    c = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (c) begin
        if (v[i*4 +: 4] >= f_lim(i)) begin
          v[i*4 +: 4] = 4'd0;
        end else begin
          v[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, v};
  endfunction

  // Decrement with digit-wise borrow
  function automatic logic [23:0] f_dec(input logic [23:0] t);
    logic [23:0] v;
    logic        b;
    v = t;
    b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (b) begin
        if (v[i*4 +: 4] == 4'd0) begin
          v[i*4 +: 4] = f_lim(i);
        end else begin
          v[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return v;
  endfunction

  // True when every digit lies inside its field range
  function automatic logic f_valid(input logic [23:0] t);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (t[i*4 +: 4] > f_lim(i)) ok = 1'b0;
    end
    return ok;
  endfunction

  state_t              r_state;
  logic                r_running;
  logic                r_lap_hold;
  logic                r_ss_old;
  logic                r_lr_old;
  logic                r_mode_down;
  logic [c_PW-1:0]     r_pre;
  logic [23:0]         r_time;
  logic                r_overflow;
  logic                r_done;
  logic [23:0]         r_frozen;
  logic [LAP_AW-1:0]   r_wr_ptr;
  logic [LAP_AW:0]     r_lap_count;
  logic [23:0]         r_lap_rd;
  logic [23:0]         r_lap_mem [LAP_DEPTH];

  state_t              w_state_nxt;
  logic                w_lap_cap;
  logic                w_clear;
  logic                w_ss_ev;
  logic                w_lr_ev;
  logic                w_is_run;
  logic                w_tick;
  logic                w_time_zero;
  logic [24:0]         w_inc_full;
  logic [23:0]         w_dec;
  logic                w_hit_zero;
  logic [LAP_AW-1:0]   w_rd_idx;

  // A press counts only if the other button is not held in the same cycle
  assign w_ss_ev     = bus.btn_ss & ~r_ss_old & ~bus.btn_lr;
  assign w_lr_ev     = bus.btn_lr & ~r_lr_old & ~bus.btn_ss;
  assign w_is_run    = (r_state == S_RUN) || (r_state == S_LAP_RUN);
  assign w_tick      = w_is_run && (r_pre == c_TICK_MAX);
  assign w_time_zero = (r_time == 24'h0);
  assign w_inc_full  = f_inc(r_time);
  assign w_dec       = f_dec(r_time);
  assign w_hit_zero  = w_tick && r_mode_down && (w_dec == 24'h0);
  assign w_rd_idx    = r_wr_ptr - LAP_AW'(1) - bus.lap_sel;

  // Next state from button events; a countdown reaching zero overrides to STOP
  always_comb begin
    w_state_nxt = r_state;
    w_lap_cap   = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_ss_ev && !(bus.mode_down && w_time_zero)) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_ss_ev) begin
          w_state_nxt = S_STOP;
        end else if (w_lr_ev) begin
          w_state_nxt = S_LAP_RUN;
          w_lap_cap   = 1'b1;
        end
      end
      S_LAP_RUN: begin
        if (w_ss_ev)      w_state_nxt = S_LAP_STOP;
        else if (w_lr_ev) w_state_nxt = S_RUN;
      end
      S_LAP_STOP: begin
        if (w_ss_ev)      w_state_nxt = S_LAP_RUN;
        else if (w_lr_ev) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_ss_ev && !(r_mode_down && w_time_zero)) begin
          w_state_nxt = S_RUN;
        end else if (w_lr_ev) begin
          w_state_nxt = S_IDLE;
          w_clear     = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_hit_zero) w_state_nxt = S_STOP;
  end

  // State register with registered running/lap_hold decodes
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_running  <= 1'b0;
      r_lap_hold <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_running  <= (w_state_nxt == S_RUN) || (w_state_nxt == S_LAP_RUN);
      r_lap_hold <= (w_state_nxt == S_LAP_RUN) || (w_state_nxt == S_LAP_STOP);
    end
  end

  // Button history for rising-edge detection
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_ss_old <= 1'b0;
      r_lr_old <= 1'b0;
    end else begin
      r_ss_old <= bus.btn_ss;
      r_lr_old <= bus.btn_lr;
    end
  end

  // Centisecond prescaler: runs in RUN/LAP_RUN, holds when stopped, clears in IDLE
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_pre <= '0;
    end else if (r_state == S_IDLE || w_clear) begin
      r_pre <= '0;
    end else if (w_is_run) begin
      r_pre <= w_tick ? '0 : r_pre + c_PW'(1);
    end
  end

  // Time register, direction latch, overflow and done
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_time      <= 24'h0;
      r_mode_down <= 1'b0;
      r_overflow  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_hit_zero;
      if (r_state == S_IDLE) r_mode_down <= bus.mode_down;
      if (w_clear) begin
        r_time     <= 24'h0;
        r_overflow <= 1'b0;
      end else if (r_state == S_IDLE) begin
        if (bus.load && f_valid(bus.preset_bcd)) r_time <= bus.preset_bcd;
      end else if (w_tick) begin
        if (r_mode_down) begin
          r_time <= w_dec;
        end else begin
          r_time <= w_inc_full[23:0];
          if (w_inc_full[24]) r_overflow <= 1'b1;
        end
      end
    end
  end

  // Lap bookkeeping: frozen display copy, write pointer and saturating count
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_frozen    <= 24'h0;
      r_wr_ptr    <= '0;
      r_lap_count <= '0;
    end else if (w_clear) begin
      r_wr_ptr    <= '0;
      r_lap_count <= '0;
    end else if (w_lap_cap) begin
      r_frozen <= r_time;
      r_wr_ptr <= r_wr_ptr + LAP_AW'(1);
      if (r_lap_count != c_LAP_FULL) r_lap_count <= r_lap_count + (LAP_AW + 1)'(1);
    end
  end

  // Lap storage; entries beyond lap_count are never read out, so no reset
  always_ff @(posedge clk_in) begin
    if (w_lap_cap) r_lap_mem[r_wr_ptr] <= r_time;
  end

  // Registered lap readout, newest-first, zero for unused slots
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_lap_rd <= 24'h0;
    end else if ({1'b0, bus.lap_sel} < r_lap_count) begin
      r_lap_rd <= r_lap_mem[w_rd_idx];
    end else begin
      r_lap_rd <= 24'h0;
    end
  end

  assign bus.time_bcd   = r_time;
  assign bus.disp_bcd   = r_lap_hold ? r_frozen : r_time;
  assign bus.lap_rd_bcd = r_lap_rd;
  assign bus.lap_count  = r_lap_count;
  assign bus.state      = r_state;
  assign bus.running    = r_running;
  assign bus.lap_hold   = r_lap_hold;
  assign bus.overflow   = r_overflow;
  assign bus.done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_chrono_lap_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_chrono_lap_core
// Description : Scoreboard bench for chrono_lap_core. A time-in-centiseconds
//               reference model predicts every output per clock; a monitor
//               compares the DUT against the queued predictions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chrono_lap_core;

  localparam int TICK_DIV  = 4;
  localparam int LAP_DEPTH = 4;
  localparam int LAP_AW    = 2;
  localparam int IDLE = 0, STOP = 1, RUN = 2, LAP_RUN = 3, LAP_STOP = 4;

  typedef struct {
    logic [2:0]  st;
    logic [23:0] tm;
    logic [23:0] dp;
    logic [23:0] rd;
    logic [31:0] lc;
    logic        run;
    logic        hold;
    logic        ovf;
    logic        dn;
  } exp_t;

  logic clk_in  = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_in = ~clk_in;

  chrono_lap_core_if #(.LAP_AW(LAP_AW)) bus ();

  chrono_lap_core #(
    .TICK_DIV (TICK_DIV),
    .LAP_DEPTH(LAP_DEPTH),
    .LAP_AW   (LAP_AW)
  ) dut (
    .clk_in (clk_in),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int   n_pass  = 0;
  int   n_total = 0;
  exp_t q[$];

  // Reference model state: time kept as a plain centisecond count
  int   m_state, m_cs, m_pre, m_frozen;
  bit   m_down, m_ovf, m_done, m_old_ss, m_old_lr;
  int   m_laps[$];
  logic [23:0] m_rd;

  bit          g_md;
  logic [23:0] g_pre;
  logic [1:0]  g_sel;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
  endtask

  function automatic logic [23:0] to_bcd(input int cs);
    int mm, ss, cc;
    mm = cs / 6000;
    ss = (cs / 100) % 60;
    cc = cs % 100;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
  endfunction

  function automatic int from_bcd(input logic [23:0] b);
    return (int'(b[23:20]) * 10 + int'(b[19:16])) * 6000 +
           (int'(b[15:12]) * 10 + int'(b[11:8])) * 100 +
           int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic bit bcd_ok(input logic [23:0] b);
    return b[23:20] <= 5 && b[19:16] <= 9 && b[15:12] <= 5 &&
           b[11:8] <= 9 && b[7:4] <= 9 && b[3:0] <= 9;
  endfunction

  task automatic model_reset();
    m_state = IDLE; m_cs = 0; m_pre = 0; m_frozen = 0;
    m_down = 0; m_ovf = 0; m_done = 0; m_old_ss = 0; m_old_lr = 0;
    m_laps.delete();
    m_rd = 24'h0;
  endtask

  // One clock of behaviour given the inputs sampled at that edge
  task automatic model_step(input bit ss, input bit lr, input bit md, input bit ld,
                            input logic [23:0] pre, input int sel);
    bit sse, lre, run, tick, hit;
    int ns, cs_n;
    sse = ss && !m_old_ss && !lr;
    lre = lr && !m_old_lr && !ss;
    m_old_ss = ss;
    m_old_lr = lr;
    m_rd = (sel < m_laps.size()) ? to_bcd(m_laps[sel]) : 24'h0;
    run  = (m_state == RUN) || (m_state == LAP_RUN);
    tick = run && (m_pre == TICK_DIV - 1);
    cs_n = m_cs;
    hit  = 0;
    ns   = m_state;
    if (tick) begin
      if (m_down) begin
        cs_n = m_cs - 1;
        hit  = (cs_n == 0);
      end else begin
        cs_n = m_cs + 1;
        if (cs_n == 60 * 60 * 100) begin
          cs_n  = 0;
          m_ovf = 1;
        end
      end
    end
    if (m_state == IDLE) m_pre = 0;
    else if (run) m_pre = tick ? 0 : m_pre + 1;
    case (m_state)
      IDLE: begin
        if (ld && bcd_ok(pre)) cs_n = from_bcd(pre);
        if (sse && !(md && m_cs == 0)) ns = RUN;
        m_down = md;
      end
      RUN: begin
        if (sse) ns = STOP;
        else if (lre) begin
          ns = LAP_RUN;
          m_laps.push_front(m_cs);
          if (m_laps.size() > LAP_DEPTH) void'(m_laps.pop_back());
          m_frozen = m_cs;
        end
      end
      LAP_RUN:  if (sse) ns = LAP_STOP; else if (lre) ns = RUN;
      LAP_STOP: if (sse) ns = LAP_RUN;  else if (lre) ns = STOP;
      STOP: begin
        if (sse && !(m_down && m_cs == 0)) ns = RUN;
        else if (lre) begin
          ns = IDLE; cs_n = 0; m_ovf = 0; m_pre = 0;
          m_laps.delete();
        end
      end
      default: ns = IDLE;
    endcase
    if (hit) ns = STOP;
    m_done  = hit;
    m_cs    = cs_n;
    m_state = ns;
  endtask

  // Drive one clock of inputs and queue the outputs expected after that edge
  task automatic cycle(input bit ss, input bit lr, input bit ld);
    exp_t e;
    @(negedge clk_in);
    bus.btn_ss     = ss;
    bus.btn_lr     = lr;
    bus.mode_down  = g_md;
    bus.load       = ld;
    bus.preset_bcd = g_pre;
    bus.lap_sel    = g_sel;
    model_step(ss, lr, g_md, ld, g_pre, int'(g_sel));
    e.st   = 3'(m_state);
    e.tm   = to_bcd(m_cs);
    e.dp   = (m_state == LAP_RUN || m_state == LAP_STOP) ? to_bcd(m_frozen) : e.tm;
    e.rd   = m_rd;
    e.lc   = m_laps.size();
    e.run  = (m_state == RUN || m_state == LAP_RUN);
    e.hold = (m_state == LAP_RUN || m_state == LAP_STOP);
    e.ovf  = m_ovf;
    e.dn   = m_done;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0);
  endtask

  task automatic pulse_ss();
    cycle(1, 0, 0);
    cycle(0, 0, 0);
  endtask

  task automatic pulse_lr();
    cycle(0, 1, 0);
    cycle(0, 0, 0);
  endtask

  // Wait for the edge of the last queued cycle, then settle
  task automatic peek();
    @(posedge clk_in);
    #2;
  endtask

  task automatic chk_all_zero();
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_time", 32'(bus.time_bcd), 0);
    chk("rst_disp", 32'(bus.disp_bcd), 0);
    chk("rst_laprd", 32'(bus.lap_rd_bcd), 0);
    chk("rst_flags", {27'd0, bus.lap_count != 0, bus.running, bus.lap_hold,
                      bus.overflow, bus.done}, 0);
  endtask

  // Monitor: compare DUT outputs with the queued prediction after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_in);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("state", 32'(bus.state), 32'(e.st));
        chk("time_bcd", 32'(bus.time_bcd), 32'(e.tm));
        chk("disp_bcd", 32'(bus.disp_bcd), 32'(e.dp));
        chk("lap_rd_bcd", 32'(bus.lap_rd_bcd), 32'(e.rd));
        chk("lap_count", 32'(bus.lap_count), e.lc);
        chk("running", 32'(bus.running), 32'(e.run));
        chk("lap_hold", 32'(bus.lap_hold), 32'(e.hold));
        chk("overflow", 32'(bus.overflow), 32'(e.ovf));
        chk("done", 32'(bus.done), 32'(e.dn));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    bus.btn_ss = 0; bus.btn_lr = 0; bus.mode_down = 0; bus.load = 0;
    bus.preset_bcd = 0; bus.lap_sel = 0;
    g_md = 0; g_pre = 0; g_sel = 0;
    model_reset();
    #1;
    chk_all_zero();
    repeat (3) @(posedge clk_in);
    #2 reset_n = 1'b1;

    // One second of counting, then stop
    pulse_ss();
    idle(399);
    peek();
    chk("one_sec_time", 32'(bus.time_bcd), 32'h000100);
    chk("one_sec_running", 32'(bus.running), 1);
    cycle(1, 0, 0);
    peek();
    chk("stop_state", 32'(bus.state), 1);
    chk("stop_time_held", 32'(bus.time_bcd), 32'h000100);
    idle(3);

    // Asynchronous reset in the middle of a run
    pulse_ss();
    idle(10);
    @(posedge clk_in);
    #3 reset_n = 1'b0;
    #1;
    chk_all_zero();
    repeat (3) @(posedge clk_in);
    #2 reset_n = 1'b1;
    model_reset();

    // Five lap pairs fill and wrap the lap memory
    pulse_ss();
    idle(5);
    for (int k = 0; k < 5; k++) begin
      cycle(0, 1, 0);
      idle(7);
      cycle(0, 1, 0);
      idle(7);
    end
    peek();
    chk("laps_full", 32'(bus.lap_count), 4);
    for (int s = 0; s < 4; s++) begin
      g_sel = 2'(s);
      idle(2);
    end
    g_sel = 0;
    pulse_ss();
    pulse_lr();

    // Up-count wrap sets overflow; out-of-range preset is ignored
    g_md = 0;
    g_pre = 24'h595998;
    cycle(0, 0, 1);
    cycle(1, 0, 0);
    idle(8);
    peek();
    chk("wrap_time", 32'(bus.time_bcd), 0);
    chk("wrap_overflow", 32'(bus.overflow), 1);
    pulse_ss();
    pulse_lr();
    g_pre = 24'h001234;
    cycle(0, 0, 1);
    g_pre = 24'h0A0000;
    cycle(0, 0, 1);
    peek();
    chk("bad_load_ignored", 32'(bus.time_bcd), 32'h001234);

    // Countdown to zero stops and pulses done once
    g_md = 1;
    g_pre = 24'h000002;
    cycle(0, 0, 1);
    cycle(1, 0, 0);
    idle(8);
    peek();
    chk("cd_done", 32'(bus.done), 1);
    chk("cd_state", 32'(bus.state), 1);
    chk("cd_time", 32'(bus.time_bcd), 0);
    idle(1);
    peek();
    chk("cd_done_once", 32'(bus.done), 0);
    pulse_ss();
    peek();
    chk("cd_no_restart", 32'(bus.state), 1);
    pulse_lr();

    // Simultaneous press ignored; LR walks LAP_STOP -> STOP -> IDLE
    g_md = 0;
    pulse_ss();
    idle(3);
    cycle(1, 1, 0);
    peek();
    chk("both_ignored", 32'(bus.state), 2);
    idle(1);
    pulse_lr();
    pulse_ss();
    pulse_lr();
    peek();
    chk("lapstop_to_stop", 32'(bus.state), 1);
    pulse_lr();
    peek();
    chk("back_idle", 32'(bus.state), 0);
    chk("idle_lap_count", 32'(bus.lap_count), 0);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      bit ss, lr, ld;
      ss = ($urandom_range(0, 7) == 0);
      lr = ($urandom_range(0, 7) == 0);
      ld = !ss && ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 31) == 0) g_md = ~g_md;
      g_sel = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0:       g_pre = to_bcd($urandom_range(0, 359999));
        1:       g_pre = to_bcd($urandom_range(0, 30));
        default: g_pre = 24'($urandom);
      endcase
      cycle(ss, lr, ld);
    end

    idle(2);
    peek();
    chk("scoreboard_drained", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
